bcd_counter_mux7seg: RTL
========================

# bcd_counter_mux7seg

Parametrised multi-digit BCD up/down counter with an integrated tick prescaler and a time-multiplexed, active-low 7-segment display driver. It replaces single-digit, fixed-rate counters on board demos: one instance drives a shared segment bus plus per-digit anodes. It also exposes the packed BCD value and a wrap pulse for cascading or for downstream logic.

## Interface
- `DIGITS`, default 4: number of BCD digits, range 1..8.
- `TICK_DIV`, default 50_000_000: iclk cycles per count tick, ≥2 (1 Hz at 50 MHz).
- `SCAN_DIV`, default 50_000: iclk cycles each digit is lit, ≥1.
- `iclk` input, 1 bit: system clock; every register is in this domain.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `en` input, 1 bit: count enable; sampled only on tick cycles.
- `up` input, 1 bit: 1 counts up, 0 counts down.
- `clr` input, 1 bit: synchronous clear of count and prescaler; has priority over `en`.
- `count` output, 4*DIGITS bits: packed BCD value, digit 0 in [3:0].
- `seg` output, 7 bits: {g,f,e,d,c,b,a}, active low, registered.
- `an` output, DIGITS bits: digit select, active low, one-hot-low, registered.
- `wrap` output, 1 bit: one-cycle pulse on counter wrap, registered.
- `terminal` output, 1 bit: combinational; all digits 9 when `up`=1, all digits 0 when `up`=0.

## Operation
- Prescaler: counts 0..TICK_DIV-1 and restarts at 0. Internal `tick` is high while the prescaler equals TICK_DIV-1.
- Count update happens on an iclk edge with `tick`=1 and `en`=1:
  - up: digit 0 increments. A digit at 9 becomes 0 and carries into the next digit.
  - down: digit 0 decrements. A digit at 0 becomes 9 and borrows from the next digit.
  - All 99…9 going up gives 00…0. All 00…0 going down gives 99…9. In both cases `wrap`=1 on the following cycle.
- `clr`=1: `count`=0 and prescaler=0 at the next edge. Tick is suppressed that cycle and no `wrap` pulse is produced.
- `en`=0: the prescaler keeps running and `count` holds.
- `up` may change at any time; it takes effect on the next tick.
- Scan:
  - A scan counter runs 0..SCAN_DIV-1. At each terminal count, the digit index advances 0→1→…→DIGITS-1→0.
  - `an` drives low only the bit at the digit index.
  - `seg` shows the decode of that digit.
  - `an` and `seg` update on the same edge, so there is no ghosting.
- Decode uses 0x3F,06,5B,4F,66,6D,7D,07,7F,67 for values 0..9, inverted for active-low output. Any value ≥10 gives `seg`=7'h7F (blank).
- Reset values: `count`=0, prescaler=0, scan counter=0, digit index=0, `an`=~1, `seg`=~7'h3F, `wrap`=0. Assertion mid-count clears everything immediately. After reset is released, the first tick occurs TICK_DIV cycles later.

## Timing
- The count changes on the edge where `tick`=1. `count` is valid one cycle after that edge; latency is 1.
- `wrap` is high for exactly the one cycle after the wrapping edge.
- Tick period is exactly TICK_DIV cycles, and each digit is lit for exactly SCAN_DIV cycles.
- A full scan frame is DIGITS*SCAN_DIV cycles.
- `seg`/`an` reflect `count` at most one cycle late; there is no stale mix within a single digit slot.
- `clr` and `tick` in the same cycle: clear wins.

## Configuration
- `BCD_CNT_BLANK_LEADING_EN` defined: leading-zero blanking is enabled.
  - When digit k shows 0 and all digits above k are 0, `seg`=7'h7F for digit k.
  - Digit 0 is never blanked.
  - `an` scanning is unchanged.
- Not defined: every digit shows its value, including leading zeros.

## Test plan
- Reset: hold `rst_n`=0 with DIGITS=2, TICK_DIV=4, SCAN_DIV=2, then release → `count`=8'h00, `an`=2'b10, `seg`=7'b1000000. First increment to 8'h01 occurs 4 cycles after release.
- Up wrap: run from 8'h98 with `up`=1, `en`=1 → 8'h99, then 8'h00. `wrap` is high one cycle after the 99→00 edge, and `terminal`=1 while the count is 99.
- Down wrap: run from 8'h01 with `up`=0 → 8'h00, then 8'h99. `wrap` pulses once and `terminal`=1 at 00.
- Controls: `en`=0 across 3 ticks → `count` holds. Assert `clr` on a tick cycle → `count`=00 and no `wrap`.
- Scan: `count`=8'h47 → `an` alternates 10/01 every 2 cycles, with `seg`=~7'h07 when `an`=10 and `seg`=~7'h66 when `an`=01.
- Blanking: build with `BCD_CNT_BLANK_LEADING_EN` and `count`=8'h05 → digit 1 `seg`=7'h7F and digit 0 `seg`=~7'h6D. Build without the macro → digit 1 `seg`=~7'h3F.

Source files
------------

// File: rtl/bcd_counter_mux7seg.sv
// Multi-digit BCD up/down counter with tick prescaler and a time-multiplexed,
// active-low 7-segment driver. Optional leading-zero blanking is enabled by
// defining BCD_CNT_BLANK_LEADING_EN.
module bcd_counter_mux7seg #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned SCAN_DIV = 50_000
) (
  input  logic                  iclk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   count,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  wrap,
  output logic                  terminal
);

  localparam int unsigned CW     = 4 * DIGITS;
  localparam int unsigned PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIGITS-1:0] AN_RST = ~DIGITS'(1);

  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CW-1:0]     count_q, count_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              wrap_q, wrap_d;

  logic              tick;
  logic              all9, all0;
  logic [CW-1:0]     next_val;
  logic              carry;
  logic [3:0]        dig, nxt;
  logic [3:0]        dig_sel;
  logic              blank_sel;

  // Active-high segment pattern {g,f,e,d,c,b,a}; non-decimal values are dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h67;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  assign tick     = (presc_q == PRE_W'(TICK_DIV - 1));
  assign terminal = up ? all9 : all0;

  // All-nines / all-zeros detection on the current count.
  always_comb begin
    all9 = 1'b1;
    all0 = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      all9 = all9 && (count_q[4*i +: 4] == 4'd9);
      all0 = all0 && (count_q[4*i +: 4] == 4'd0);
    end
  end

  // Prescaler, ripple-carry BCD step, clear priority and wrap detection.
  always_comb begin
    count_d  = count_q;
    wrap_d   = 1'b0;
    presc_d  = tick ? '0 : presc_q + PRE_W'(1);
    next_val = '0;
    carry    = 1'b1;
    dig      = '0;
    nxt      = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = count_q[4*i +: 4];
      nxt = dig;
      if (carry) begin
        if (up) begin
          if (dig >= 4'd9) begin
            nxt = 4'd0;
          end else begin
            nxt   = dig + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (dig == 4'd0) begin
            nxt = 4'd9;
          end else begin
            nxt   = dig - 4'd1;
            carry = 1'b0;
          end
        end
      end
      next_val[4*i +: 4] = nxt;
    end
    if (clr) begin
      count_d = '0;
      presc_d = '0;
    end else if (tick && en) begin
      count_d = next_val;
      wrap_d  = terminal;
    end
  end

`ifdef BCD_CNT_BLANK_LEADING_EN
  logic [DIGITS-1:0] blank;
  logic              zero_above;

  // A digit blanks when it and every higher digit are zero; digit 0 always shows.
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above && (count_d[4*k +: 4] == 4'd0);
      blank[k]   = zero_above && (k != 0);
    end
  end
`else
  logic [DIGITS-1:0] blank;
  assign blank = '0;
`endif

  // Scan timing plus anode/segment selection from next-cycle state, so the
  // registered an/seg always agree with the registered digit index and count.
  always_comb begin
    scan_d = scan_q + SCAN_W'(1);
    idx_d  = idx_q;
    if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_d = '0;
      idx_d  = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    an_d      = '1;
    dig_sel   = '0;
    blank_sel = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_d == IDX_W'(k)) begin
        an_d[k]   = 1'b0;
        dig_sel   = count_d[4*k +: 4];
        blank_sel = blank[k];
      end
    end
    seg_d = blank_sel ? 7'h7F : ~seg_decode(dig_sel);
  end

  // State registers.
  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      scan_q  <= '0;
      idx_q   <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
      an_q    <= AN_RST;
      seg_q   <= ~7'h3F;
    end else begin
      presc_q <= presc_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign count = count_q;
  assign seg   = seg_q;
  assign an    = an_q;
  assign wrap  = wrap_q;

endmodule
